// File: rtl/anc_core_mc.sv
// anc_core_mc: time-multiplexed multi-channel FIR/LMS active noise control core.
// One shared MAC per clock walks the TAPS taps of the active channel, updating
// that channel's weight bank in the same pass when adaptation is enabled.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE with no weight inject pending; out_valid is a
// one-cycle strobe and out_sample/out_ch hold until the next output.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   sample handshake
//   in_ch, x_in, e_in   channel tag, reference sample, error sample
//   mu_in               non-negative step size
//   adapt_en, bypass    per-channel adapt enable, global adaptation freeze
//   leak_en             weight leakage enable
//   wr_en/wr_ch/wr_tap/wr_data  weight inject port (IDLE only)
//   out_valid, out_ch, out_sample  filter output strobe, tag and value
module anc_core_mc #(
  parameter int DW      = 16,
  parameter int WW      = 26,
  parameter int TAPS    = 64,
  parameter int M       = 6,
  parameter int CH      = 2,
  parameter int CW      = 1,
  parameter int UPD_SH  = 6,
  parameter int LEAK_SH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] e_in,
  input  logic signed [DW-1:0] mu_in,
  input  logic [CH-1:0]        adapt_en,
  input  logic                 bypass,
  input  logic                 leak_en,
  input  logic                 wr_en,
  input  logic [CW-1:0]        wr_ch,
  input  logic [M-1:0]         wr_tap,
  input  logic [WW-1:0]        wr_data,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [DW-1:0] out_sample
);

  localparam int FB   = WW - 2;
  localparam int MW   = 2 * DW;
  localparam int PW   = WW + DW;
  localparam int ACCW = WW + DW + M;
  localparam int LW   = ACCW + 2;   // common width for saturation checks

  localparam logic signed [LW-1:0] DW_MAX = {{(LW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [LW-1:0] DW_MIN = {{(LW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [LW-1:0] WW_MAX = {{(LW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [LW-1:0] WW_MIN = {{(LW-WW+1){1'b1}}, {(WW-1){1'b0}}};

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [LW-1:0] v);
    if (v > DW_MAX)      sat_dw = DW_MAX[DW-1:0];
    else if (v < DW_MIN) sat_dw = DW_MIN[DW-1:0];
    else                 sat_dw = v[DW-1:0];
  endfunction

  function automatic logic signed [WW-1:0] sat_ww(input logic signed [LW-1:0] v);
    if (v > WW_MAX)      sat_ww = WW_MAX[WW-1:0];
    else if (v < WW_MIN) sat_ww = WW_MIN[WW-1:0];
    else                 sat_ww = v[WW-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;
  state_t state, state_nx;

  logic signed [WW-1:0] w [0:CH-1][0:TAPS-1];
  logic signed [DW-1:0] x [0:CH-1][0:TAPS-1];

  logic [CW-1:0]          ch_q;
  logic signed [DW-1:0]   e_q, mu_q, mu_e;
  logic                   upd_q, leak_q;
  logic [M-1:0]           k;
  logic signed [ACCW-1:0] acc;

  logic hs, ch_ok, wr_ok, last;

  // Datapath intermediates
  logic signed [WW-1:0]   w_cur, leak_v, w_new;
  logic signed [DW-1:0]   x_cur, out_nx, mue_nx;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_nx, acc_sh;
  logic signed [MW-1:0]   mx, mx_sh, mu_prod, mu_sh;
  logic signed [LW-1:0]   w_sum;

  assign ch_ok = {1'b0, in_ch} < (CW+1)'(CH);
  assign wr_ok = {1'b0, wr_ch} < (CW+1)'(CH);
  assign hs    = in_valid && in_ready;
  assign last  = (k == M'(TAPS - 1));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !wr_en;
        // Out-of-range channels are consumed without starting a pass
        if (in_valid && !wr_en && ch_ok) state_nx = LOAD;
      end
      LOAD: state_nx = MAC;
      MAC:  if (last) state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shared MAC / LMS update arithmetic for the current tap of the active channel
  always_comb begin
    w_cur   = w[ch_q][k];
    x_cur   = x[ch_q][k];
    prod    = {{DW{w_cur[WW-1]}}, w_cur} * {{WW{x_cur[DW-1]}}, x_cur};
    acc_nx  = acc + {{M{prod[PW-1]}}, prod};
    acc_sh  = acc_nx >>> FB;
    out_nx  = sat_dw({{(LW-ACCW){acc_sh[ACCW-1]}}, acc_sh});
    mx      = {{DW{mu_e[DW-1]}}, mu_e} * {{DW{x_cur[DW-1]}}, x_cur};
    mx_sh   = mx >>> UPD_SH;
    leak_v  = w_cur >>> LEAK_SH;
    w_sum   = {{(LW-WW){w_cur[WW-1]}}, w_cur}
            + {{(LW-MW){mx_sh[MW-1]}}, mx_sh}
            - (leak_q ? {{(LW-WW){leak_v[WW-1]}}, leak_v} : {LW{1'b0}});
    w_new   = sat_ww(w_sum);
    mu_prod = {{DW{mu_q[DW-1]}}, mu_q} * {{DW{e_q[DW-1]}}, e_q};
    mu_sh   = mu_prod >>> (DW - 1);
    mue_nx  = sat_dw({{(LW-MW){mu_sh[MW-1]}}, mu_sh});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      e_q        <= '0;
      mu_q       <= '0;
      mu_e       <= '0;
      upd_q      <= 1'b0;
      leak_q     <= 1'b0;
      k          <= '0;
      acc        <= '0;
      out_ch     <= '0;
      out_sample <= '0;
      for (int c = 0; c < CH; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          w[c][t] <= '0;
          x[c][t] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (wr_ok) w[wr_ch][wr_tap] <= wr_data;
          end else if (hs && ch_ok) begin
            ch_q   <= in_ch;
            e_q    <= e_in;
            mu_q   <= mu_in;
            upd_q  <= adapt_en[in_ch] && !bypass;
            leak_q <= leak_en;
            for (int t = TAPS - 1; t > 0; t--) x[in_ch][t] <= x[in_ch][t-1];
            x[in_ch][0] <= x_in;
          end
        end
        LOAD: begin
          mu_e <= mue_nx;
          acc  <= '0;
          k    <= '0;
        end
        MAC: begin
          acc <= acc_nx;
          k   <= k + 1'b1;
          // Leakage rides on the update term, so it is off whenever upd_q is
          if (upd_q) w[ch_q][k] <= w_new;
          // Output registered on the final tap so it lines up with the OUT strobe
          if (last) begin
            out_sample <= out_nx;
            out_ch     <= ch_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/anc_core_mc.md
Name: anc_core_mc

Overview:
- Next-generation ANC core: controller and FIR/LMS datapath merged into one parametrised, time-multiplexed engine serving CH independent channels.
- One shared MAC per clock. Each channel keeps its own delay line and weight bank.
- New over the single-channel core: channel tagging, per-channel adapt enable, optional weight leakage, and a gated weight-inject port.
- Sits between the sample front-end and the DAC path.

Parameters:
DW, 16, sample/error/step width (signed Q1.(DW-1))
WW, 26, weight width (signed, FB=WW-2 fractional bits)
TAPS, 64, taps per channel (power of 2)
M, 6, log2(TAPS)
CH, 2, channel count
CW, 1, channel index width (>= log2(CH), min 1)
UPD_SH, 6, right shift applied to mu_e*x before weight add
LEAK_SH, 12, leakage shift

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
in_valid  in  1  sample offered
in_ready  out  1  core idle, able to accept
in_ch  in  CW  channel of offered sample
x_in  in  DW  reference sample
e_in  in  DW  error mic sample for this channel (from previous output)
mu_in  in  DW  step size, non-negative
adapt_en  in  CH  per-channel adaptation enable
bypass  in  1  global adaptation freeze (filter still runs)
leak_en  in  1  enable weight leakage
wr_en  in  1  weight inject strobe
wr_ch  in  CW  inject channel
wr_tap  in  M  inject tap
wr_data  in  WW  inject value
out_valid  out  1  one-cycle output strobe
out_ch  out  CW  channel of out_sample
out_sample  out  DW  filter output

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. rst asserted clears all weights and delay lines, state=IDLE, out_valid=0, out_sample=0, out_ch=0. All inputs are ignored while rst=1. Reset mid-operation aborts the pass with no out_valid.
- in_ready = (state==IDLE) && !wr_en (combinational).
- FSM states: IDLE -> LOAD -> MAC -> OUT -> IDLE.
- IDLE:
  - wr_en=1 writes w[wr_ch][wr_tap] and has priority over in_valid.
  - wr_en is ignored in any other state. wr_ch>=CH is ignored.
  - A handshake (in_valid && in_ready) latches in_ch, e_in, mu_in and the update flag upd = adapt_en[in_ch] && !bypass. It shifts x_in into x[in_ch][0]; oldest sample drops. Next state LOAD.
- Out-of-range channel: in_ch>=CH is accepted, discarded, state stays IDLE, no output.
- LOAD (1 cycle): mu_e = sat_DW((mu*e) >>> (DW-1)). Clear acc.
- MAC (TAPS cycles, k=0..TAPS-1):
  - acc += w[k]*x[k], using the pre-update weight.
  - If upd: w[k] <= sat_WW(w[k] + ((mu_e*x[k]) >>> UPD_SH) - (leak_en ? w[k]>>>LEAK_SH : 0)).
  - If !upd, weights are unchanged; leakage is also suppressed.
  - Only the active channel's bank is touched.
- acc width: WW+DW+M. All shifts arithmetic (truncate toward -inf).
- OUT (1 cycle): out_sample <= sat_DW(acc >>> FB), out_ch <= latched ch, out_valid=1. Outputs hold until the next OUT.
- Latency: handshake in cycle 0 -> out_valid in cycle TAPS+2. Next accept is possible in cycle TAPS+3.
- Saturation clamps to signed max/min of the target width; no wrap anywhere.
- bypass/adapt_en/leak_en are sampled at handshake only; mid-pass changes have no effect.

Test Plan:
(CH=2, TAPS=4, DW=16, WW=26; 1.0 = 26'h1000000)
- Reset, mu=0, in ch0 x=16'h4000 -> out_valid exactly 6 cycles after handshake, out_sample=0, out_ch=0; in_ready low cycles 1-6.
- Inject w[0][0]=1.0, w[0][1]=0.5 (26'h0800000), bypass=1; ch0 x=16'h2000 then 16'h1000 -> outputs 16'h2000 then 16'h2000 (0x1000+0x1000); weights unchanged.
- Inject w[1][0]=-1.0 (26'h3000000); ch1 x=16'h1000 -> out_sample=16'hF000, out_ch=1; a following ch0 output matches the previous scenario's ch0 history.
- Zero weights, adapt_en=2'b01, bypass=0, mu=16'h7FFF, e=16'h4000, ch0 x=16'h4000 -> out 0; w[0][0]=26'h03FFF00. Then x=16'h4000, e=0 -> out 16'h0FFF. Repeat with leak_en=1, LEAK_SH=12 -> w[0][0] loses 26'h3FF on the second pass.
- Inject w[0][0]=26'h1FFFFFF; x=16'h7FFF -> out 16'h7FFF; x=16'h8000 -> out 16'h8000 (saturation both rails).
- Protocol: wr_en pulse during MAC -> no weight change. in_valid held during busy -> accepted only when IDLE. in_ch=1 with CH=1 build -> no out_valid. rst pulse mid-MAC -> no out_valid; all weights read 0 afterwards.
